uart_port_responder: RTL

Device-side endpoint of the CPU serial port handshake at address 0xBF00.
- Accepts bus write strobes (wrn) and read strobes (rdn) from the memory controller.
- Drives the tbre, tsre and data_ready status lines back to it.
- Converts bytes to and from an asynchronous 8N1 serial line (txd/rxd).
- Replaces the external UART chip in simulation and standalone builds.

---
 rtl/uart_port_responder.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_port_responder.sv
// Device-side endpoint of the CPU serial port at 0xBF00: bus strobe handshake plus 8N1 UART.
// Define UART_PARITY_EN to switch both directions to 11-bit frames with even parity.
module uart_port_responder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tbre,
  output logic       tsre,
  output logic       data_ready,
  output logic       txd,
  input  logic       rxd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
`endif

  // Synchronizers, preset high so reset looks like an idle bus and line
  logic [SYNC_STAGES-1:0] wrn_sync_q, wrn_sync_d;
  logic [SYNC_STAGES-1:0] rdn_sync_q, rdn_sync_d;
  logic [SYNC_STAGES-1:0] rxd_sync_q, rxd_sync_d;
  logic wrn_dly_q, wrn_dly_d, rdn_dly_q, rdn_dly_d, rxd_dly_q, rxd_dly_d;
  logic wrn_s, rdn_s, rxd_s, wrn_rise, rdn_rise, rxd_fall;

  always_comb begin
    wrn_sync_d = {wrn_sync_q[SYNC_STAGES-2:0], wrn};
    rdn_sync_d = {rdn_sync_q[SYNC_STAGES-2:0], rdn};
    rxd_sync_d = {rxd_sync_q[SYNC_STAGES-2:0], rxd};
    wrn_s      = wrn_sync_q[SYNC_STAGES-1];
    rdn_s      = rdn_sync_q[SYNC_STAGES-1];
    rxd_s      = rxd_sync_q[SYNC_STAGES-1];
    wrn_dly_d  = wrn_s;
    rdn_dly_d  = rdn_s;
    rxd_dly_d  = rxd_s;
    wrn_rise   = wrn_s & ~wrn_dly_q;
    rdn_rise   = rdn_s & ~rdn_dly_q;
    rxd_fall   = ~rxd_s & rxd_dly_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrn_sync_q <= '1;
      rdn_sync_q <= '1;
      rxd_sync_q <= '1;
      wrn_dly_q  <= 1'b1;
      rdn_dly_q  <= 1'b1;
      rxd_dly_q  <= 1'b1;
    end else begin
      wrn_sync_q <= wrn_sync_d;
      rdn_sync_q <= rdn_sync_d;
      rxd_sync_q <= rxd_sync_d;
      wrn_dly_q  <= wrn_dly_d;
      rdn_dly_q  <= rdn_dly_d;
      rxd_dly_q  <= rxd_dly_d;
    end
  end

  // Transmit path
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  thr_q, thr_d;
  logic        tbre_q, tbre_d, txd_q, txd_d, tx_load;
`ifdef UART_PARITY_EN
  logic        tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    thr_d      = thr_q;
    tbre_d     = tbre_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (wrn_rise && tbre_q) begin
      thr_d  = data_in;
      tbre_d = 1'b0;
    end
    case (tx_state_q)
      TX_IDLE: tx_load = ~tbre_q;
      TX_START:
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      TX_DATA:
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            txd_d      = tx_par_q;
            tx_state_d = TX_PARITY;
`else
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 16'd1;
`ifdef UART_PARITY_EN
      TX_PARITY:
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
`endif
      TX_STOP:
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (!tbre_q) tx_load = 1'b1;
          else tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      default: tx_state_d = TX_IDLE;
    endcase
    // A pending THR is pulled in from IDLE or straight out of STOP with no idle gap
    if (tx_load) begin
      tx_shift_d = thr_q;
      tbre_d     = 1'b1;
      txd_d      = 1'b0;
      tx_cnt_d   = '0;
      tx_state_d = TX_START;
`ifdef UART_PARITY_EN
      tx_par_d   = ^thr_q;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      thr_q      <= '0;
      tbre_q     <= 1'b1;
      txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      thr_q      <= thr_d;
      tbre_q     <= tbre_d;
      txd_q      <= txd_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // Receive path
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rbr_q, rbr_d;
  logic        ready_q, ready_d, rx_load;
`ifdef UART_PARITY_EN
  logic        rx_perr_q, rx_perr_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rbr_d      = rbr_q;
    ready_d    = ready_q;
    rx_load    = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      RX_IDLE:
        if (rxd_fall) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      RX_START:
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
`ifdef UART_PARITY_EN
          rx_perr_d = 1'b0;
`endif
          rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_DATA:
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end
        end else rx_cnt_d = rx_cnt_q + 16'd1;
`ifdef UART_PARITY_EN
      RX_PARITY:
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rxd_s ^ (^rx_shift_q);
          rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
`endif
      RX_STOP:
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (!rxd_s) rx_state_d = RX_BREAK;
          else begin
            rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
            rx_load    = ~rx_perr_q;
`else
            rx_load    = 1'b1;
`endif
          end
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_BREAK: if (rxd_s) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
    // Ordering matters: a completed byte overrides a same-cycle read acknowledge
    if (rdn_rise) ready_d = 1'b0;
    if (rx_load) begin
      rbr_d   = rx_shift_q;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rbr_q      <= '0;
      ready_q    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rbr_q      <= rbr_d;
      ready_q    <= ready_d;
`ifdef UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign data_out   = rbr_q;
  assign data_oe    = ~rdn_s;
  assign data_ready = ready_q;
  assign tbre       = tbre_q;
  assign tsre       = (tx_state_q == TX_IDLE);
  assign txd        = txd_q;

endmodule
